// File: rtl/change_dispenser.sv
// Coin payout controller: pays an amount (in nickels) greedily as dimes then nickels
// through a two-chute hopper, one timed eject pulse per coin, then strobes done.
module change_dispenser #(
  parameter int AMT_W     = 5,
  parameter int PULSE_CYC = 10,
  parameter int GAP_CYC   = 5
) (
  input  logic             hz100,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             hopper_ready,
  input  logic             dime_empty,
  output logic             dime_out,
  output logic             nickel_out,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] dimes_paid,
  output logic [AMT_W-1:0] nickels_paid
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHOOSE,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_dime_q, is_dime_d;
  logic [AMT_W-1:0] dimes_q, dimes_d;
  logic [AMT_W-1:0] nickels_q, nickels_d;
  logic             dime_out_q, dime_out_d;
  logic             nickel_out_q, nickel_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    is_dime_d = is_dime_q;
    dimes_d   = dimes_q;
    nickels_d = nickels_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d     = amount;
          dimes_d   = '0;
          nickels_d = '0;
          state_d   = S_CHOOSE;
        end
      end
      S_CHOOSE: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else if (hopper_ready) begin
          is_dime_d = (rem_q >= AMT_W'(2)) && !dime_empty;
          cnt_d     = CNT_W'(PULSE_CYC - 1);
          state_d   = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          // Coin is committed only once its full pulse has been delivered.
          if (is_dime_q) begin
            rem_d   = rem_q - AMT_W'(2);
            dimes_d = (dimes_q == '1) ? dimes_q : dimes_q + AMT_W'(1);
          end else begin
            rem_d     = rem_q - AMT_W'(1);
            nickels_d = (nickels_q == '1) ? nickels_q : nickels_q + AMT_W'(1);
          end
          if (GAP_CYC == 0) begin
            state_d = S_CHOOSE;
          end else begin
            cnt_d   = CNT_W'(GAP_CYC - 1);
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_CHOOSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of the next-state decode.
    dime_out_d   = (state_d == S_PULSE) && is_dime_d;
    nickel_out_d = (state_d == S_PULSE) && !is_dime_d;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge hz100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      cnt_q        <= '0;
      is_dime_q    <= 1'b0;
      dimes_q      <= '0;
      nickels_q    <= '0;
      dime_out_q   <= 1'b0;
      nickel_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      is_dime_q    <= is_dime_d;
      dimes_q      <= dimes_d;
      nickels_q    <= nickels_d;
      dime_out_q   <= dime_out_d;
      nickel_out_q <= nickel_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign dime_out     = dime_out_q;
  assign nickel_out   = nickel_out_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dimes_paid   = dimes_q;
  assign nickels_paid = nickels_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coin sequences are queued from a
// greedy model when a payout is started and popped against observed eject pulses.
module tb_change_dispenser;
  localparam int AMT_W = 5;
  localparam byte CD = 8'h44;  // 'D'
  localparam byte CN = 8'h4E;  // 'N'

  logic             hz100 = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AMT_W-1:0] amount = '0;
  logic             hopper_ready = 1'b1;
  logic             dime_empty = 1'b0;
  logic             dime_out, nickel_out, busy, done;
  logic [AMT_W-1:0] dimes_paid, nickels_paid;

  int  n_checks = 0;
  int  n_fail = 0;
  byte exp_q[$];
  byte obs_q[$];
  int  exp_dimes, exp_nickels;
  int  r_done_cnt, r_done_lat, r_bad_len, r_overlap, r_stall_viol, r_idle_early;
  bit  r_timeout;

  change_dispenser #(.AMT_W(AMT_W), .PULSE_CYC(2), .GAP_CYC(1)) dut (
    .hz100(hz100), .rst_n(rst_n), .start(start), .amount(amount),
    .hopper_ready(hopper_ready), .dime_empty(dime_empty),
    .dime_out(dime_out), .nickel_out(nickel_out), .busy(busy), .done(done),
    .dimes_paid(dimes_paid), .nickels_paid(nickels_paid)
  );

  always #5 hz100 = ~hz100;

  // Greedy reference: dimes while >=2 remain and the dime chute is still stocked.
  function automatic void model(input int amt, input int empty_after);
    int rem;
    exp_q.delete();
    rem = amt;
    exp_dimes = 0;
    exp_nickels = 0;
    while (rem > 0) begin
      if (rem >= 2 && !(empty_after >= 0 && exp_dimes >= empty_after)) begin
        exp_q.push_back(CD); rem -= 2; exp_dimes++;
      end else begin
        exp_q.push_back(CN); rem -= 1; exp_nickels++;
      end
    end
  endfunction

  // Runs one payout and records observed coins plus protocol statistics.
  task automatic run_txn(input int amt, input int stall, input int empty_after,
                         input int restart_at, input int restart_amt);
    int  cyc, len, dseen;
    byte cur, prev;
    bit  fin;
    obs_q.delete();
    r_done_cnt = 0; r_done_lat = -1; r_bad_len = 0; r_overlap = 0;
    r_stall_viol = 0; r_idle_early = 0;
    prev = 0; len = 0; dseen = 0; fin = 0;
    hopper_ready = (stall > 0) ? 1'b0 : 1'b1;
    dime_empty = (empty_after == 0);
    amount = AMT_W'(amt);
    start = 1'b1;
    @(posedge hz100); #1;
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 3000) begin
      cur = dime_out ? CD : (nickel_out ? CN : 8'h00);
      if (dime_out && nickel_out) r_overlap++;
      if (cyc <= stall && cur != 0) r_stall_viol++;
      if (!busy && r_done_cnt == 0) r_idle_early++;
      if (cur != 0 && cur == prev) begin
        len++;
      end else begin
        if (prev != 0) begin
          if (len != 2) r_bad_len++;
          if (prev == CD) dseen++;
          if (empty_after > 0 && dseen == empty_after) dime_empty = 1'b1;
        end
        if (cur != 0) begin
          obs_q.push_back(cur);
          len = 1;
        end
      end
      prev = cur;
      if (done) begin
        r_done_cnt++;
        if (r_done_cnt == 1) r_done_lat = cyc;
      end
      if (r_done_cnt > 0 && !busy) fin = 1;
      if (cyc == stall) hopper_ready = 1'b1;
      if (cyc == restart_at) begin
        start = 1'b1;
        amount = AMT_W'(restart_amt);
      end else begin
        start = 1'b0;
      end
      if (!fin) begin
        @(posedge hz100); #1;
        cyc++;
      end
    end
    r_timeout = !fin;
    start = 1'b0;
    repeat (3) begin
      @(posedge hz100); #1;
      if (done) r_done_cnt++;
    end
    dime_empty = 1'b0;
    hopper_ready = 1'b1;
  endtask

  task automatic test_reset();
    int waited;
    n_checks++;
    if ({dime_out, nickel_out, busy, done, dimes_paid, nickels_paid} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %b/%b/%b/%b/%0d/%0d want all 0", dime_out, nickel_out, busy, done, dimes_paid, nickels_paid);
    end
    @(posedge hz100); #1;
    rst_n = 1'b1;
    amount = AMT_W'(3);
    start = 1'b1;
    @(posedge hz100); #1;
    start = 1'b0;
    waited = 0;
    while (!dime_out && waited < 10) begin
      @(posedge hz100); #1;
      waited++;
    end
    n_checks++;
    if (dime_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pulse_seen: dime_out=%b want 1", dime_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dime_out, nickel_out, busy, done, dimes_paid, nickels_paid} !== '0) begin
      n_fail++;
      $display("FAIL reset_midpulse: got %b/%b/%b/%b/%0d/%0d want all 0", dime_out, nickel_out, busy, done, dimes_paid, nickels_paid);
    end
    @(posedge hz100); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge hz100);
    #1;
    n_checks++;
    if ({dime_out, nickel_out, busy, done, dimes_paid, nickels_paid} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle_after: got %b/%b/%b/%b/%0d/%0d want all 0", dime_out, nickel_out, busy, done, dimes_paid, nickels_paid);
    end
    $display("reset: mid-pulse reset dropped eject, idle after release");
  endtask

  task automatic test_timing_example();
    logic [3:0] exp_v[$];
    logic [3:0] e, o;
    // {dime_out, nickel_out, busy, done} for cycles 1..11 after start
    exp_v = '{4'b0010, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0110,
              4'b0110, 4'b0010, 4'b0010, 4'b0011, 4'b0000};
    amount = AMT_W'(3);
    start = 1'b1;
    for (int k = 1; exp_v.size() > 0; k++) begin
      @(posedge hz100); #1;
      start = 1'b0;
      e = exp_v.pop_front();
      o = {dime_out, nickel_out, busy, done};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL timing_cycle%0d: got %b want %b", k, o, e);
      end
    end
    n_checks++;
    if (dimes_paid !== 5'd1 || nickels_paid !== 5'd1) begin
      n_fail++;
      $display("FAIL timing_counts: got %0d/%0d want 1/1", dimes_paid, nickels_paid);
    end
    $display("timing: amount=3 waveform compared over 11 cycles, paid %0d/%0d", dimes_paid, nickels_paid);
  endtask

  task automatic test_nickels_only();
    byte e, o;
    model(5, 0);
    run_txn(5, 0, 0, -1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'h3F;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL nickels_coin: got %c want %c", o, e); end
    end
    n_checks++;
    if (obs_q.size() != 0 || r_timeout || r_done_cnt != 1 || r_bad_len != 0 || r_overlap != 0) begin
      n_fail++;
      $display("FAIL nickels_proto: extra=%0d timeout=%0d done=%0d badlen=%0d overlap=%0d want 0/0/1/0/0", obs_q.size(), r_timeout, r_done_cnt, r_bad_len, r_overlap);
    end
    n_checks++;
    if (dimes_paid !== AMT_W'(exp_dimes) || nickels_paid !== AMT_W'(exp_nickels)) begin
      n_fail++;
      $display("FAIL nickels_counts: got %0d/%0d want %0d/%0d", dimes_paid, nickels_paid, exp_dimes, exp_nickels);
    end
    $display("nickels_only: amount=5 dime_empty=1 paid %0d/%0d", dimes_paid, nickels_paid);
  endtask

  task automatic test_stall();
    byte e, o;
    model(4, -1);
    run_txn(4, 20, -1, -1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'h3F;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL stall_coin: got %c want %c", o, e); end
    end
    n_checks++;
    if (r_stall_viol != 0 || r_idle_early != 0) begin
      n_fail++;
      $display("FAIL stall_hold: pulses_in_stall=%0d not_busy_cycles=%0d want 0/0", r_stall_viol, r_idle_early);
    end
    n_checks++;
    if (obs_q.size() != 0 || r_timeout || r_done_cnt != 1 || r_bad_len != 0) begin
      n_fail++;
      $display("FAIL stall_proto: extra=%0d timeout=%0d done=%0d badlen=%0d want 0/0/1/0", obs_q.size(), r_timeout, r_done_cnt, r_bad_len);
    end
    n_checks++;
    if (dimes_paid !== AMT_W'(exp_dimes) || nickels_paid !== AMT_W'(exp_nickels)) begin
      n_fail++;
      $display("FAIL stall_counts: got %0d/%0d want %0d/%0d", dimes_paid, nickels_paid, exp_dimes, exp_nickels);
    end
    $display("stall: amount=4 hopper held off 20 cycles, paid %0d/%0d", dimes_paid, nickels_paid);
  endtask

  task automatic test_zero();
    run_txn(0, 0, -1, -1, 0);
    n_checks++;
    if (r_done_lat != 2 || r_done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_done: latency=%0d count=%0d want 2/1", r_done_lat, r_done_cnt);
    end
    n_checks++;
    if (obs_q.size() != 0 || dimes_paid !== '0 || nickels_paid !== '0) begin
      n_fail++;
      $display("FAIL zero_nopulse: pulses=%0d paid=%0d/%0d want 0/0/0", obs_q.size(), dimes_paid, nickels_paid);
    end
    $display("zero: amount=0 done at cycle %0d", r_done_lat);
  endtask

  task automatic test_back_to_back();
    byte e, o;
    model(3, -1);
    run_txn(3, 0, -1, 3, 31);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'h3F;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL restart_coin: got %c want %c", o, e); end
    end
    n_checks++;
    if (obs_q.size() != 0 || r_timeout || r_done_cnt != 1) begin
      n_fail++;
      $display("FAIL restart_proto: extra=%0d timeout=%0d done=%0d want 0/0/1", obs_q.size(), r_timeout, r_done_cnt);
    end
    n_checks++;
    if (dimes_paid !== AMT_W'(exp_dimes) || nickels_paid !== AMT_W'(exp_nickels)) begin
      n_fail++;
      $display("FAIL restart_counts: got %0d/%0d want %0d/%0d", dimes_paid, nickels_paid, exp_dimes, exp_nickels);
    end
    $display("back_to_back: start during busy ignored, paid %0d/%0d", dimes_paid, nickels_paid);
  endtask

  task automatic test_max_amount();
    byte e, o;
    model(31, 3);
    run_txn(31, 0, 3, -1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'h3F;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL max_coin: got %c want %c", o, e); end
    end
    n_checks++;
    if (obs_q.size() != 0 || r_timeout || r_done_cnt != 1 || r_bad_len != 0 || r_overlap != 0) begin
      n_fail++;
      $display("FAIL max_proto: extra=%0d timeout=%0d done=%0d badlen=%0d overlap=%0d want 0/0/1/0/0", obs_q.size(), r_timeout, r_done_cnt, r_bad_len, r_overlap);
    end
    n_checks++;
    if (dimes_paid !== AMT_W'(exp_dimes) || nickels_paid !== AMT_W'(exp_nickels)) begin
      n_fail++;
      $display("FAIL max_counts: got %0d/%0d want %0d/%0d", dimes_paid, nickels_paid, exp_dimes, exp_nickels);
    end
    $display("max_amount: amount=31 dimes run out after 3, paid %0d/%0d", dimes_paid, nickels_paid);
  endtask

  initial begin
    #1;
    test_reset();
    test_timing_example();
    test_nickels_only();
    test_stall();
    test_zero();
    test_back_to_back();
    test_max_amount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
